// File: rtl/spi_cmd_parser_if.sv
// Byte-stream input and decoded command outputs of spi_cmd_parser.
// The slave modport is the parser side; master is the driver/observer side.
interface spi_cmd_parser_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  spi_cs_n_in;
    logic                  byte_rdy_in;
    logic [7:0]            byte_data_in;
    logic                  cfg_wr_out;
    logic [7:0]            cfg_data_out;
    logic                  ram_wr_en_out;
    logic [ADDR_WIDTH-1:0] ram_wr_addr_out;
    logic [7:0]            ram_wr_data_out;
    logic                  frame_rdy_out;

    modport master (
        output spi_cs_n_in, byte_rdy_in, byte_data_in,
        input  cfg_wr_out, cfg_data_out, ram_wr_en_out, ram_wr_addr_out,
               ram_wr_data_out, frame_rdy_out
    );

    modport slave (
        input  spi_cs_n_in, byte_rdy_in, byte_data_in,
        output cfg_wr_out, cfg_data_out, ram_wr_en_out, ram_wr_addr_out,
               ram_wr_data_out, frame_rdy_out
    );
endinterface

// File: rtl/spi_cmd_parser.sv
// SPI command parser: decodes config and pixel-data commands from the SPI byte stream.
// Define SPI_CMD_PARSER_WRAP_EN to make data writes wrap around the RAM instead of stopping at the end.
module spi_cmd_parser #(
    parameter int         ADDR_WIDTH = 9,
    parameter logic [7:0] CMD_CONF   = 8'h2A,
    parameter logic [7:0] CMD_DATA   = 8'h2C,
    parameter logic [7:0] CFG_RST    = 8'h00
) (
    input  logic            clk_in,
    input  logic            rst_in,
    spi_cmd_parser_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CONF, S_DATA, S_DISC} state_t;

    state_t                r_state, w_state_nx;
    logic                  r_cs_meta, r_cs_s;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic                  r_wrote, w_wrote_nx;
    logic                  w_acc, w_cs_rise, w_cfg_wr, w_ram_wr, w_frame;
    logic                  r_cfg_wr, r_ram_wr, r_frame;
    logic [7:0]            r_cfg_data, r_ram_data;
    logic [ADDR_WIDTH-1:0] r_ram_addr;

    // Rise is flagged on the cycle cs_s is about to go high, so a byte landing
    // in that same cycle is still accepted and processed before returning to IDLE.
    assign w_cs_rise = r_cs_meta & ~r_cs_s;
    assign w_acc     = bus.byte_rdy_in & ~r_cs_s;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_wrote_nx = r_wrote;
        w_cfg_wr   = 1'b0;
        w_ram_wr   = 1'b0;
        w_frame    = 1'b0;
        case (r_state)
            S_IDLE: if (w_acc) begin
                if (bus.byte_data_in == CMD_CONF) begin
                    w_state_nx = S_CONF;
                end else if (bus.byte_data_in == CMD_DATA) begin
                    w_state_nx = S_DATA;
                    w_cnt_nx   = '0;
                    w_wrote_nx = 1'b0;
                end else begin
                    w_state_nx = S_DISC;
                end
            end
            S_CONF: if (w_acc) begin
                w_cfg_wr   = 1'b1;
                w_state_nx = S_DISC;
            end
            S_DATA: if (w_acc) begin
                w_ram_wr   = 1'b1;
                w_cnt_nx   = r_cnt + 1'b1;
                w_wrote_nx = 1'b1;
`ifdef SPI_CMD_PARSER_WRAP_EN
                w_state_nx = S_DATA;
`else
                if (r_cnt == {ADDR_WIDTH{1'b1}}) w_state_nx = S_DISC;
`endif
            end
            S_DISC: w_state_nx = S_DISC;
            default: w_state_nx = S_IDLE;
        endcase
        if (w_cs_rise) begin
            w_state_nx = S_IDLE;
            w_frame    = ((r_state == S_DATA) || (r_state == S_DISC)) && w_wrote_nx;
            w_wrote_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cs_meta  <= 1'b1;
            r_cs_s     <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wrote    <= 1'b0;
            r_cfg_wr   <= 1'b0;
            r_cfg_data <= CFG_RST;
            r_ram_wr   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= 8'h00;
            r_frame    <= 1'b0;
        end else begin
            r_cs_meta <= bus.spi_cs_n_in;
            r_cs_s    <= r_cs_meta;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_wrote   <= w_wrote_nx;
            r_cfg_wr  <= w_cfg_wr;
            r_ram_wr  <= w_ram_wr;
            r_frame   <= w_frame;
            if (w_cfg_wr) r_cfg_data <= bus.byte_data_in;
            if (w_ram_wr) begin
                r_ram_addr <= r_cnt;
                r_ram_data <= bus.byte_data_in;
            end
        end
    end

    assign bus.cfg_wr_out      = r_cfg_wr;
    assign bus.cfg_data_out    = r_cfg_data;
    assign bus.ram_wr_en_out   = r_ram_wr;
    assign bus.ram_wr_addr_out = r_ram_addr;
    assign bus.ram_wr_data_out = r_ram_data;
    assign bus.frame_rdy_out   = r_frame;
endmodule

// File: tb/tb_spi_cmd_parser.sv
// Randomized self-checking bench for spi_cmd_parser against a frame-level reference model.
module tb_spi_cmd_parser;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;
`ifdef SPI_CMD_PARSER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    spi_cmd_parser_if #(.ADDR_WIDTH(AW)) bus();

    spi_cmd_parser #(.ADDR_WIDTH(AW), .CMD_CONF(8'h2A), .CMD_DATA(8'h2C), .CFG_RST(8'h00)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // observed events, stamped with the cycle they were seen in
    int mon_a[$], mon_d[$], mon_c[$], fr_c[$];
    int cfg_n;
    always @(negedge clk_in) begin
        if (bus.ram_wr_en_out === 1'b1) begin
            mon_a.push_back(int'(bus.ram_wr_addr_out));
            mon_d.push_back(int'(bus.ram_wr_data_out));
            mon_c.push_back(cyc);
        end
        if (bus.cfg_wr_out === 1'b1) cfg_n++;
        if (bus.frame_rdy_out === 1'b1) fr_c.push_back(cyc);
    end

    logic [7:0] tx[$];
    int snd_c[$];
    int cs_up;
    int exp_a[$], exp_d[$], exp_c[$];
    int exp_cfg_n, exp_fr_n;
    logic [7:0] cfg_model;

    task automatic mon_clear();
        mon_a.delete(); mon_d.delete(); mon_c.delete(); fr_c.delete(); cfg_n = 0;
    endtask

    // One chip-select frame carrying tx[], random idle gaps of up to gapmax cycles
    task automatic send_frame(input int gapmax);
        @(negedge clk_in);
        mon_clear();
        snd_c.delete();
        bus.spi_cs_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        foreach (tx[i]) begin
            snd_c.push_back(cyc);
            bus.byte_data_in = tx[i];
            bus.byte_rdy_in  = 1'b1;
            @(negedge clk_in);
            bus.byte_rdy_in  = 1'b0;
            if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk_in);
        end
        repeat (2) @(negedge clk_in);
        cs_up = cyc;
        bus.spi_cs_n_in = 1'b1;
        repeat (6) @(negedge clk_in);
    endtask

    // Frame-level model: what the opcode says the frame should produce
    task automatic model_frame();
        exp_a.delete(); exp_d.delete(); exp_c.delete();
        exp_cfg_n = 0;
        exp_fr_n  = 0;
        if (tx.size() >= 2 && tx[0] == 8'h2A) begin
            exp_cfg_n = 1;
            cfg_model = tx[1];
        end
        if (tx.size() >= 1 && tx[0] == 8'h2C) begin
            for (int i = 1; i < tx.size(); i++) begin
                if (WRAP || (i - 1) < DEPTH) begin
                    exp_a.push_back((i - 1) % DEPTH);
                    exp_d.push_back(int'(tx[i]));
                    exp_c.push_back(snd_c[i] + 1);
                end
            end
            exp_fr_n = (tx.size() >= 2) ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        bus.spi_cs_n_in = 1'b1; bus.byte_rdy_in = 1'b0; bus.byte_data_in = 8'h00;
        repeat (3) @(negedge clk_in);
        total++; if (bus.cfg_wr_out !== 1'b0) begin bad++; $display("FAIL reset_cfg_wr got=%b exp=0", bus.cfg_wr_out); end
        total++; if (bus.cfg_data_out !== 8'h00) begin bad++; $display("FAIL reset_cfg_data got=%h exp=00", bus.cfg_data_out); end
        total++; if (bus.ram_wr_en_out !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", bus.ram_wr_en_out); end
        total++; if (bus.ram_wr_addr_out !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.ram_wr_addr_out); end
        total++; if (bus.ram_wr_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.ram_wr_data_out); end
        total++; if (bus.frame_rdy_out !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", bus.frame_rdy_out); end
        rst_in = 1'b0;
        cfg_model = 8'h00;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_conf();
        tx.delete(); tx.push_back(8'h2A); tx.push_back(8'h5F);
        send_frame(1);
        model_frame();
        total++; if (cfg_n !== exp_cfg_n) begin bad++; $display("FAIL conf_pulses got=%0d exp=%0d", cfg_n, exp_cfg_n); end
        total++; if (bus.cfg_data_out !== cfg_model) begin bad++; $display("FAIL conf_data got=%h exp=%h", bus.cfg_data_out, cfg_model); end
        total++; if (mon_a.size() !== 0) begin bad++; $display("FAIL conf_writes got=%0d exp=0", mon_a.size()); end
        total++; if (fr_c.size() !== 0) begin bad++; $display("FAIL conf_frame got=%0d exp=0", fr_c.size()); end
    endtask

    // Random opcodes, lengths and gaps (gap 0 gives back-to-back bytes)
    task automatic test_data();
        for (int f = 0; f < 10; f++) begin
            int op = $urandom_range(3, 0);
            tx.delete();
            if (f == 0) begin
                tx.push_back(8'h2C); tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
            end else begin
                if (op == 0) tx.push_back(8'h2A);
                else if (op == 3) tx.push_back(8'h80 | 8'($urandom_range(127, 0)));
                else tx.push_back(8'h2C);
                repeat ($urandom_range(12, 0)) tx.push_back(8'($urandom));
            end
            send_frame((f == 0) ? 0 : int'($urandom_range(2, 0)));
            model_frame();
            total++; if (mon_a.size() !== exp_a.size()) begin bad++; $display("FAIL data%0d_nwr got=%0d exp=%0d", f, mon_a.size(), exp_a.size()); end
            for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
                total++;
                if (mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i] || mon_c[i] !== exp_c[i]) begin
                    bad++; $display("FAIL data%0d_wr%0d got=(%0d,%h,@%0d) exp=(%0d,%h,@%0d)", f, i, mon_a[i], mon_d[i], mon_c[i], exp_a[i], exp_d[i], exp_c[i]);
                end
            end
            total++; if (cfg_n !== exp_cfg_n) begin bad++; $display("FAIL data%0d_cfg got=%0d exp=%0d", f, cfg_n, exp_cfg_n); end
            total++; if (bus.cfg_data_out !== cfg_model) begin bad++; $display("FAIL data%0d_cfgval got=%h exp=%h", f, bus.cfg_data_out, cfg_model); end
            total++; if (fr_c.size() !== exp_fr_n) begin bad++; $display("FAIL data%0d_frame got=%0d exp=%0d", f, fr_c.size(), exp_fr_n); end
            if (fr_c.size() == 1 && exp_fr_n == 1) begin
                total++; if (fr_c[0] !== cs_up + 2) begin bad++; $display("FAIL data%0d_frame_cyc got=%0d exp=%0d", f, fr_c[0], cs_up + 2); end
            end
        end
    endtask

    task automatic test_disc();
        tx.delete(); tx.push_back(8'h7E); tx.push_back(8'h2C); tx.push_back(8'hAA);
        send_frame(0);
        total++; if (mon_a.size() + cfg_n + fr_c.size() !== 0) begin bad++; $display("FAIL disc_strobes got=%0d exp=0", mon_a.size() + cfg_n + fr_c.size()); end
        tx.delete(); tx.push_back(8'h2C); tx.push_back(8'h01);
        send_frame(0);
        model_frame();
        total++; if (mon_a.size() !== 1) begin bad++; $display("FAIL disc_next_nwr got=%0d exp=1", mon_a.size()); end
        if (mon_a.size() >= 1) begin
            total++;
            if (mon_a[0] !== exp_a[0] || mon_d[0] !== exp_d[0] || mon_c[0] !== exp_c[0]) begin
                bad++; $display("FAIL disc_next_wr got=(%0d,%h,@%0d) exp=(%0d,%h,@%0d)", mon_a[0], mon_d[0], mon_c[0], exp_a[0], exp_d[0], exp_c[0]);
            end
        end
        total++; if (fr_c.size() !== 1) begin bad++; $display("FAIL disc_next_frame got=%0d exp=1", fr_c.size()); end
    endtask

    task automatic test_end_of_ram();
        tx.delete(); tx.push_back(8'h2C);
        for (int i = 0; i < DEPTH + 2; i++) tx.push_back(8'(i));
        send_frame(0);
        model_frame();
        total++; if (mon_a.size() !== exp_a.size()) begin bad++; $display("FAIL eor_nwr got=%0d exp=%0d", mon_a.size(), exp_a.size()); end
        for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++) begin
            total++;
            if (mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i] || mon_c[i] !== exp_c[i]) begin
                bad++; $display("FAIL eor_wr%0d got=(%0d,%h,@%0d) exp=(%0d,%h,@%0d)", i, mon_a[i], mon_d[i], mon_c[i], exp_a[i], exp_d[i], exp_c[i]);
            end
        end
        total++; if (fr_c.size() !== 1) begin bad++; $display("FAIL eor_frame got=%0d exp=1", fr_c.size()); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_in);
        mon_clear();
        bus.spi_cs_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            bus.byte_data_in = (i == 0) ? 8'h2C : 8'($urandom);
            bus.byte_rdy_in  = 1'b1;
            @(negedge clk_in);
            bus.byte_rdy_in  = 1'b0;
        end
        #1 rst_in = 1'b1;
        #1;
        total++; if (mon_a.size() !== 3) begin bad++; $display("FAIL rmid_prewrites got=%0d exp=3", mon_a.size()); end
        total++; if (bus.ram_wr_addr_out !== '0 || bus.ram_wr_data_out !== 8'h00) begin bad++; $display("FAIL rmid_addr_data got=(%h,%h) exp=(0,00)", bus.ram_wr_addr_out, bus.ram_wr_data_out); end
        total++; if (bus.cfg_data_out !== 8'h00) begin bad++; $display("FAIL rmid_cfg got=%h exp=00", bus.cfg_data_out); end
        total++; if (bus.ram_wr_en_out !== 1'b0 || bus.cfg_wr_out !== 1'b0) begin bad++; $display("FAIL rmid_strobes got=%b%b exp=00", bus.ram_wr_en_out, bus.cfg_wr_out); end
        cfg_model = 8'h00;
        bus.spi_cs_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (6) @(negedge clk_in);
        total++; if (fr_c.size() !== 0) begin bad++; $display("FAIL rmid_frame got=%0d exp=0", fr_c.size()); end
        tx.delete(); tx.push_back(8'h2C); tx.push_back(8'h9C);
        send_frame(0);
        model_frame();
        total++; if (mon_a.size() !== 1) begin bad++; $display("FAIL rmid_next_nwr got=%0d exp=1", mon_a.size()); end
        if (mon_a.size() >= 1) begin
            total++;
            if (mon_a[0] !== exp_a[0] || mon_d[0] !== exp_d[0] || mon_c[0] !== exp_c[0]) begin
                bad++; $display("FAIL rmid_next_wr got=(%0d,%h,@%0d) exp=(%0d,%h,@%0d)", mon_a[0], mon_d[0], mon_c[0], exp_a[0], exp_d[0], exp_c[0]);
            end
        end
        total++; if (fr_c.size() !== 1) begin bad++; $display("FAIL rmid_next_frame got=%0d exp=1", fr_c.size()); end
    endtask

    task automatic test_cs_edge();
        int c2, c3;
        @(negedge clk_in);
        mon_clear();
        for (int i = 0; i < 3; i++) begin
            bus.byte_data_in = (i == 0) ? 8'h2A : ((i == 1) ? 8'h2C : 8'h11);
            bus.byte_rdy_in  = 1'b1;
            @(negedge clk_in);
            bus.byte_rdy_in  = 1'b0;
        end
        repeat (3) @(negedge clk_in);
        total++; if (mon_a.size() + cfg_n + fr_c.size() !== 0) begin bad++; $display("FAIL csh_strobes got=%0d exp=0", mon_a.size() + cfg_n + fr_c.size()); end
        bus.spi_cs_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        bus.byte_data_in = 8'h2C; bus.byte_rdy_in = 1'b1;
        @(negedge clk_in);
        c2 = cyc;
        bus.byte_data_in = 8'h11;
        @(negedge clk_in);
        bus.byte_rdy_in = 1'b0;
        bus.spi_cs_n_in = 1'b1;
        @(negedge clk_in);
        // two-flop synchronizer: this byte is sampled on the edge where cs_s rises
        c3 = cyc;
        bus.byte_data_in = 8'h22; bus.byte_rdy_in = 1'b1;
        @(negedge clk_in);
        bus.byte_rdy_in = 1'b0;
        repeat (6) @(negedge clk_in);
        total++; if (mon_a.size() !== 2) begin bad++; $display("FAIL cse_nwr got=%0d exp=2", mon_a.size()); end
        if (mon_a.size() == 2) begin
            total++; if (mon_a[0] !== 0 || mon_d[0] !== 8'h11 || mon_c[0] !== c2 + 1) begin bad++; $display("FAIL cse_wr0 got=(%0d,%h,@%0d) exp=(0,11,@%0d)", mon_a[0], mon_d[0], mon_c[0], c2 + 1); end
            total++; if (mon_a[1] !== 1 || mon_d[1] !== 8'h22 || mon_c[1] !== c3 + 1) begin bad++; $display("FAIL cse_wr1 got=(%0d,%h,@%0d) exp=(1,22,@%0d)", mon_a[1], mon_d[1], mon_c[1], c3 + 1); end
        end
        total++; if (fr_c.size() !== 1) begin bad++; $display("FAIL cse_frame got=%0d exp=1", fr_c.size()); end
        if (fr_c.size() == 1) begin
            total++; if (fr_c[0] !== c3 + 1) begin bad++; $display("FAIL cse_frame_cyc got=%0d exp=%0d", fr_c[0], c3 + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_conf();
        test_data();
        test_disc();
        test_end_of_ram();
        test_reset_mid();
        test_cs_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not finish");
    end
endmodule
